// File: rtl/product_accumulator.sv
// product_accumulator: sums a vector of 32-bit products into an ACC_W-bit result with a saturating count and sticky overflow.
// Define PRODUCT_ACC_SAT_EN to clamp the sum at all-ones on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_product,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q;
  logic ovf_q, ovf_d, out_ovf_q, out_valid_q;
  logic [ACC_W:0] sum_w;
  always_comb begin
    sum_w = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, in_product};
`ifdef PRODUCT_ACC_SAT_EN
    acc_d = (sum_w[ACC_W] || ovf_q) ? '1 : sum_w[ACC_W-1:0];
`else
    acc_d = sum_w[ACC_W-1:0];
`endif
    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    ovf_d = ovf_q | sum_w[ACC_W];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (state_q == ACCUM) begin
      if (in_valid && in_last) begin
        out_sum_q   <= acc_d;
        out_count_q <= cnt_d;
        out_ovf_q   <= ovf_d;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= 1'b0;
        state_q     <= HOLD;
      end else if (in_valid) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      state_q     <= ACCUM;
    end
  end
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
endmodule
